// File: rtl/map_loader.sv
// Game-start sequencer: draws a random map index, snapshots the selected map and
// visibility buses, then streams every cell into board storage over a valid/ready port.
module map_loader #(
  parameter int NUM_MAPS  = 15,
  parameter int CELLS     = 81,
  parameter int NO_REPEAT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [3:0]         i_random_number,
  output logic [3:0]         o_map_index,
  input  logic [4*CELLS-1:0] i_map_data,
  input  logic [2*CELLS-1:0] i_vis_data,
  output logic               o_wr_valid,
  input  logic               i_wr_ready,
  output logic [6:0]         o_wr_addr,
  output logic [3:0]         o_wr_value,
  output logic [1:0]         o_wr_vis,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_LATCH,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [4:0] LP_MAX_MAP = 5'(NUM_MAPS);
  localparam logic [6:0] LP_LAST    = 7'(CELLS - 1);
  localparam bit         LP_NOREP   = (NO_REPEAT != 0) && (NUM_MAPS != 1);

  state_t     r_state;
  logic [6:0] r_cnt;
  logic [3:0] r_map_index;
  logic [3:0] r_prev_index;
  logic       r_prev_valid;
  logic       r_wr_valid;
  logic [3:0] r_wr_value;
  logic [1:0] r_wr_vis;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_cells [CELLS];
  logic [1:0] r_vis   [CELLS];

  logic [3:0] w_rnd_m1;
  logic       w_in_range;
  logic       w_repeat;
  logic       w_accept;
  logic [6:0] w_next_cnt;
  logic       w_fire;

  // The minus-one is only committed once the draw is known to be nonzero.
  assign w_rnd_m1   = i_random_number - 4'd1;
  assign w_in_range = (i_random_number != 4'd0) && ({1'b0, i_random_number} <= LP_MAX_MAP);
  assign w_repeat   = LP_NOREP && r_prev_valid && (w_rnd_m1 == r_prev_index);
  assign w_accept   = w_in_range && !w_repeat;
  assign w_next_cnt = r_cnt + 7'd1;
  assign w_fire     = r_wr_valid && i_wr_ready;

  // Snapshot isolates the stream from later changes on the selection buses.
  always_ff @(posedge i_clk) begin
    if (r_state == S_LATCH) begin
      for (int k = 0; k < CELLS; k++) begin
        r_cells[k] <= i_map_data[4*k +: 4];
        r_vis[k]   <= i_vis_data[2*k +: 2];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_map_index  <= '0;
      r_prev_index <= '0;
      r_prev_valid <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_wr_value   <= '0;
      r_wr_vis     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (i_abort) begin
      r_state    <= S_IDLE;
      r_wr_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= S_PICK;
            r_busy  <= 1'b1;
          end
        end
        S_PICK: begin
          if (w_accept) begin
            r_map_index <= w_rnd_m1;
            r_state     <= S_LATCH;
          end
        end
        // First cell comes straight from the buses since the snapshot loads on this edge.
        S_LATCH: begin
          r_cnt      <= '0;
          r_wr_valid <= 1'b1;
          r_wr_value <= i_map_data[3:0];
          r_wr_vis   <= i_vis_data[1:0];
          r_state    <= S_STREAM;
        end
        S_STREAM: begin
          if (w_fire) begin
            if (r_cnt == LP_LAST) begin
              r_wr_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_cnt      <= w_next_cnt;
              r_wr_value <= r_cells[w_next_cnt];
              r_wr_vis   <= r_vis[w_next_cnt];
            end
          end
        end
        S_DONE: begin
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_prev_index <= r_map_index;
          r_prev_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_map_index = r_map_index;
  assign o_wr_valid  = r_wr_valid;
  assign o_wr_addr   = r_cnt;
  assign o_wr_value  = r_wr_value;
  assign o_wr_vis    = r_wr_vis;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_map_loader.sv
// Directed testbench for map_loader: map draws, rejection, no-repeat, stalls,
// abort, async reset and a second instance with a smaller map count.
module tb_map_loader;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic         i_start2;
  logic         i_abort;
  logic [3:0]   i_random_number;
  logic         i_wr_ready;
  logic [323:0] mapData;
  logic [161:0] visData;

  logic [3:0] o_map_index,  o_map_index2;
  logic       o_wr_valid,   o_wr_valid2;
  logic [6:0] o_wr_addr,    o_wr_addr2;
  logic [3:0] o_wr_value,   o_wr_value2;
  logic [1:0] o_wr_vis,     o_wr_vis2;
  logic       o_busy,       o_busy2;
  logic       o_done,       o_done2;

  logic [3:0] expVal [81];
  logic [1:0] expVis [81];
  int nChecks;
  int nErrors;

  map_loader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_random_number(i_random_number), .o_map_index(o_map_index),
    .i_map_data(mapData), .i_vis_data(visData), .o_wr_valid(o_wr_valid),
    .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr), .o_wr_value(o_wr_value),
    .o_wr_vis(o_wr_vis), .o_busy(o_busy), .o_done(o_done)
  );

  map_loader #(.NUM_MAPS(14)) dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start2), .i_abort(i_abort),
    .i_random_number(i_random_number), .o_map_index(o_map_index2),
    .i_map_data(mapData), .i_vis_data(visData), .o_wr_valid(o_wr_valid2),
    .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr2), .o_wr_value(o_wr_value2),
    .o_wr_vis(o_wr_vis2), .o_busy(o_busy2), .o_done(o_done2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic setBoard(input int seed);
    for (int k = 0; k < 81; k++) begin
      expVal[k] = 4'((k * 7 + seed) % 16);
      expVis[k] = 2'((k * 3 + seed) % 4);
      mapData[4*k +: 4] = expVal[k];
      visData[2*k +: 2] = expVis[k];
    end
  endtask

  // Start a game: random holds 'first' for 'hold' PICK cycles, then 'acc' is offered.
  task automatic applyStimulus(input logic [3:0] first, input int hold, input logic [3:0] acc,
                               input int expIdx, input int oldIdx, input int seed);
    setBoard(seed);
    i_random_number = (hold == 0) ? acc : first;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checkOutput("busy_pick", o_busy, 1);
    for (int i = 0; i < hold; i++) begin
      step();
      checkOutput("pick_no_valid", o_wr_valid, 0);
      checkOutput("pick_index_held", o_map_index, oldIdx);
    end
    i_random_number = acc;
    step();
    checkOutput("map_index", o_map_index, expIdx);
    checkOutput("latch_no_valid", o_wr_valid, 0);
    step();
  endtask

  task automatic streamCells(input int stallAt, input int abortAt, input int changeAt,
                             input int startAt, input int stopAt);
    int k;
    int stall;
    int cyc;
    k = 0; stall = 0; cyc = 0;
    while (k < 81) begin
      if (cyc > 300) begin
        checkOutput("stream_timeout", k, 81);
        return;
      end
      if (k == stopAt) return;
      checkOutput("wr_valid", o_wr_valid, 1);
      checkOutput("wr_addr", o_wr_addr, k);
      checkOutput("wr_value", o_wr_value, expVal[k]);
      checkOutput("wr_vis", o_wr_vis, expVis[k]);
      checkOutput("stream_done_low", o_done, 0);
      if (k == changeAt) begin
        mapData = ~mapData;
        visData = ~visData;
      end
      i_start = (k == startAt);
      if (k == stallAt && stall < 2) begin
        i_wr_ready = 1'b0;
        stall++;
      end else begin
        i_wr_ready = 1'b1;
      end
      if (k == abortAt) begin
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        checkOutput("abort_valid", o_wr_valid, 0);
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_done", o_done, 0);
        step();
        checkOutput("abort_done_later", o_done, 0);
        checkOutput("abort_valid_later", o_wr_valid, 0);
        return;
      end
      step();
      cyc++;
      if (i_wr_ready) k++;
    end
    i_start = 1'b0;
    i_wr_ready = 1'b1;
    checkOutput("done_pulse", o_done, 1);
    checkOutput("done_valid_low", o_wr_valid, 0);
    checkOutput("done_busy", o_busy, 1);
    step();
    checkOutput("done_cleared", o_done, 0);
    checkOutput("idle_busy", o_busy, 0);
    step();
    checkOutput("no_second_done", o_done, 0);
    checkOutput("still_idle", o_busy, 0);
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_start2 = 1'b0;
    i_abort = 1'b0;
    i_random_number = 4'd0;
    i_wr_ready = 1'b1;
    setBoard(0);
    repeat (2) step();
    checkOutput("rst_map_index", o_map_index, 0);
    checkOutput("rst_wr_valid", o_wr_valid, 0);
    checkOutput("rst_wr_addr", o_wr_addr, 0);
    checkOutput("rst_wr_value", o_wr_value, 0);
    checkOutput("rst_wr_vis", o_wr_vis, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    i_rst_n = 1'b1;
    step();

    // Smaller map count: 15 is out of range and must be retried.
    i_random_number = 4'd15;
    i_start2 = 1'b1;
    step();
    i_start2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("n14_busy", o_busy2, 1);
      checkOutput("n14_index_held", o_map_index2, 0);
      checkOutput("n14_no_valid", o_wr_valid2, 0);
    end
    i_random_number = 4'd14;
    step();
    checkOutput("n14_index", o_map_index2, 13);
    step();
    checkOutput("n14_valid", o_wr_valid2, 1);
    checkOutput("n14_other_idle", o_busy, 0);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    checkOutput("n14_abort", o_busy2, 0);

    applyStimulus(4'd5, 0, 4'd5, 4, 0, 1);
    streamCells(-1, -1, -1, -1, -1);

    applyStimulus(4'd0, 6, 4'd3, 2, 4, 2);
    streamCells(-1, -1, -1, -1, -1);

    applyStimulus(4'd7, 0, 4'd7, 6, 2, 3);
    streamCells(-1, -1, -1, -1, -1);

    applyStimulus(4'd7, 2, 4'd9, 8, 6, 4);
    streamCells(10, -1, 20, -1, -1);

    applyStimulus(4'd15, 0, 4'd15, 14, 8, 5);
    streamCells(-1, 40, -1, -1, -1);

    // Aborted game must not update the no-repeat history: 9 is still rejected.
    applyStimulus(4'd9, 2, 4'd15, 14, 14, 6);
    streamCells(-1, -1, -1, 30, -1);

    applyStimulus(4'd5, 0, 4'd5, 4, 14, 7);
    streamCells(-1, -1, -1, -1, 50);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", o_wr_valid, 0);
    checkOutput("async_rst_addr", o_wr_addr, 0);
    checkOutput("async_rst_value", o_wr_value, 0);
    checkOutput("async_rst_vis", o_wr_vis, 0);
    checkOutput("async_rst_index", o_map_index, 0);
    checkOutput("async_rst_busy", o_busy, 0);
    step();
    i_rst_n = 1'b1;
    step();

    i_start = 1'b1;
    i_abort = 1'b1;
    step();
    i_start = 1'b0;
    i_abort = 1'b0;
    checkOutput("start_abort_idle", o_busy, 0);
    step();
    checkOutput("start_abort_stay", o_busy, 0);

    // Reset clears the history, so 15 (last completed map 14) is accepted again.
    applyStimulus(4'd15, 0, 4'd15, 14, 0, 8);
    checkOutput("post_rst_stream", o_wr_valid, 1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    checkOutput("final_abort", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
